// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM encodings shared by the sequential ALU.
package alu_pkg;
  localparam logic [3:0] OP_ADC  = 4'd0;
  localparam logic [3:0] OP_SBB1 = 4'd1;
  localparam logic [3:0] OP_SBB2 = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_SAR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_MOD  = 4'd12;
  localparam logic [3:0] OP_ROL  = 4'd13;
  localparam logic [3:0] OP_ROR  = 4'd14;
  localparam logic [3:0] OP_RSV  = 4'd15;
  localparam int FL_P = 4;
  localparam int FL_S = 3;
  localparam int FL_Z = 2;
  localparam int FL_O = 1;
  localparam int FL_C = 0;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;
endpackage

// File: rtl/alu_iter.sv
// alu_iter: one-bit-per-step shift-add multiplier / restoring divider.
// hi_o/lo_o present the register values as they will be after the current step.
module alu_iter #(
  parameter int p_data_width = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    step_i,
  input  logic                    mode_i,
  input  logic [p_data_width-1:0] a_i,
  input  logic [p_data_width-1:0] b_i,
  output logic [p_data_width-1:0] hi_o,
  output logic [p_data_width-1:0] lo_o
);
  localparam int W = p_data_width;
  logic         mode_q;
  logic [W-1:0] a_q, b_q, m_q, a_d, b_d;
  logic [W:0]   sum, t, diff;
  logic         ge;
  // multiply: a=partial high, b=multiplier/low product; divide: a=remainder, b=dividend/quotient
  always_comb begin
    sum  = {1'b0, a_q} + (b_q[0] ? {1'b0, m_q} : '0);
    t    = {a_q, b_q[W-1]};
    diff = t - {1'b0, m_q};
    ge   = ~diff[W];
    a_d  = mode_q ? (ge ? diff[W-1:0] : t[W-1:0]) : sum[W:1];
    b_d  = mode_q ? {b_q[W-2:0], ge} : {sum[0], b_q[W-1:1]};
  end
  assign hi_o = a_d;
  assign lo_o = b_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
    end else if (load_i) begin
      mode_q <= mode_i;
      a_q    <= '0;
      b_q    <= a_i;
      m_q    <= b_i;
    end else if (step_i) begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with registered result/flags and start/busy/done handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int p_data_width  = 16,
  parameter int p_flags_width = 5
) (
  input  logic                     i_w_clk,
  input  logic                     i_w_reset,
  input  logic [p_data_width-1:0]  i_w_in1,
  input  logic [p_data_width-1:0]  i_w_in2,
  input  logic [3:0]               i_w_opcode,
  input  logic                     i_w_carry,
  input  logic                     i_w_start,
  input  logic                     i_w_oe,
  output logic [p_data_width-1:0]  o_w_out,
  output logic [p_flags_width-1:0] o_w_flags,
  output logic                     o_w_busy,
  output logic                     o_w_done
);
  localparam int W  = p_data_width;
  localparam int CW = $clog2(W);
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [3:0]    op_q;
  logic [W-1:0]  res_q, res_d, sc_res, it_res, it_hi, it_lo, v;
  logic [4:0]    flags_q, flags_d;
  logic [W:0]    add, sub1, sub2;
  logic          sc_c, sc_o, it_c, accept, is_iter, div0, iter_go, wr_sc, wr_it;
  assign accept  = i_w_start && state_q == ST_IDLE;
  assign is_iter = i_w_opcode == OP_MUL || i_w_opcode == OP_DIV || i_w_opcode == OP_MOD;
  assign div0    = (i_w_opcode == OP_DIV || i_w_opcode == OP_MOD) && i_w_in2 == '0;
  assign iter_go = accept && is_iter && !div0;
  assign wr_sc   = accept && !iter_go;
  assign wr_it   = state_q == ST_RUN && cnt_q == '0;
  alu_iter #(.p_data_width(W)) u_iter (
    .clk    (i_w_clk),
    .rst    (i_w_reset),
    .load_i (iter_go),
    .step_i (state_q == ST_RUN),
    .mode_i (i_w_opcode != OP_MUL),
    .a_i    (i_w_in1),
    .b_i    (i_w_in2),
    .hi_o   (it_hi),
    .lo_o   (it_lo)
  );
  // Single-cycle ops are evaluated straight from the inputs on the accepting edge.
  always_comb begin
    v      = i_w_in1 | i_w_in2;
    add    = {1'b0, i_w_in1} + {1'b0, i_w_in2} + {{W{1'b0}}, i_w_carry};
    sub1   = {1'b0, i_w_in1} - {1'b0, i_w_in2} - {{W{1'b0}}, i_w_carry};
    sub2   = {1'b0, i_w_in2} - {1'b0, i_w_in1} - {{W{1'b0}}, i_w_carry};
    sc_res = '0;
    sc_c   = 1'b0;
    sc_o   = 1'b0;
    case (i_w_opcode)
      OP_ADC: begin
        sc_res = add[W-1:0];
        sc_c   = add[W];
        sc_o   = (i_w_in1[W-1] == i_w_in2[W-1]) && (add[W-1] != i_w_in1[W-1]);
      end
      OP_SBB1: begin
        sc_res = sub1[W-1:0];
        sc_c   = sub1[W];
        sc_o   = (i_w_in1[W-1] != i_w_in2[W-1]) && (sub1[W-1] != i_w_in1[W-1]);
      end
      OP_SBB2: begin
        sc_res = sub2[W-1:0];
        sc_c   = sub2[W];
        sc_o   = (i_w_in1[W-1] != i_w_in2[W-1]) && (sub2[W-1] != i_w_in2[W-1]);
      end
      OP_NOT: sc_res = ~v;
      OP_AND: sc_res = i_w_in1 & i_w_in2;
      OP_OR:  sc_res = v;
      OP_XOR: sc_res = i_w_in1 ^ i_w_in2;
      OP_SHL: begin
        sc_res = {v[W-2:0], 1'b0};
        sc_c   = v[W-1];
        sc_o   = v[W-2] ^ v[W-1];
      end
      OP_SHR: begin
        sc_res = {1'b0, v[W-1:1]};
        sc_c   = v[0];
        sc_o   = v[W-1];
      end
      OP_SAR: begin
        sc_res = {v[W-1], v[W-1:1]};
        sc_c   = v[0];
      end
      OP_DIV, OP_MOD: begin
        sc_res = '1;
        sc_c   = 1'b1;
        sc_o   = 1'b1;
      end
      OP_ROL: begin
        sc_res = {i_w_in1[W-2:0], i_w_in1[W-1]};
        sc_c   = i_w_in1[W-1];
      end
      OP_ROR: begin
        sc_res = {i_w_in1[0], i_w_in1[W-1:1]};
        sc_c   = i_w_in1[0];
      end
      default: sc_res = '0;
    endcase
  end
  assign it_res = op_q == OP_MOD ? it_hi : it_lo;
  assign it_c   = op_q == OP_MUL && it_hi != '0;
  always_comb begin
    res_d          = wr_it ? it_res : sc_res;
    flags_d        = '0;
    flags_d[FL_P]  = ~^res_d;
    flags_d[FL_S]  = res_d[W-1];
    flags_d[FL_Z]  = res_d == '0;
    flags_d[FL_O]  = wr_it ? it_c : sc_o;
    flags_d[FL_C]  = wr_it ? it_c : sc_c;
    state_d        = accept ? (iter_go ? ST_RUN : ST_FIN) :
                     wr_it ? ST_FIN : state_q == ST_FIN ? ST_IDLE : state_q;
  end
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= i_w_opcode;
        cnt_q <= CW'(W - 1);
      end else if (state_q == ST_RUN) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (wr_sc || wr_it) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end
  assign o_w_out   = i_w_oe ? res_q : '0;
  assign o_w_flags = flags_q;
  assign o_w_busy  = state_q == ST_RUN;
  assign o_w_done  = state_q == ST_FIN;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus multi-cycle corner sequences for alu_seq.
module tb_alu_seq;
  import alu_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, carry = 1'b0, start = 1'b0, oe = 1'b1;
  logic [15:0] in1 = '0, in2 = '0, out;
  logic [3:0]  opcode = '0;
  logic [4:0]  flags;
  logic        busy, done;
  int          checks = 0, fails = 0;

  alu_seq dut (
    .i_w_clk    (clk),
    .i_w_reset  (rst),
    .i_w_in1    (in1),
    .i_w_in2    (in2),
    .i_w_opcode (opcode),
    .i_w_carry  (carry),
    .i_w_start  (start),
    .i_w_oe     (oe),
    .o_w_out    (out),
    .o_w_flags  (flags),
    .o_w_busy   (busy),
    .o_w_done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] exp_out;
    logic [4:0]  exp_fl;
    int          exp_lat;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin);
    @(negedge clk);
    opcode = op; in1 = a; in2 = b; carry = cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, nbusy, ndone;
    vecs.push_back('{OP_ADC,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 5'b01010, 1});
    vecs.push_back('{OP_ADC,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b10101, 1});
    vecs.push_back('{OP_SBB1, 16'h0005, 16'h0007, 1'b1, 16'hFFFD, 5'b01001, 1});
    vecs.push_back('{OP_SBB2, 16'h0003, 16'h000A, 1'b0, 16'h0007, 5'b00000, 1});
    vecs.push_back('{OP_NOT,  16'h00F0, 16'h0F00, 1'b0, 16'hF00F, 5'b11000, 1});
    vecs.push_back('{OP_AND,  16'h0FF0, 16'h00FF, 1'b0, 16'h00F0, 5'b10000, 1});
    vecs.push_back('{OP_OR,   16'h1200, 16'h0034, 1'b0, 16'h1234, 5'b00000, 1});
    vecs.push_back('{OP_XOR,  16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 5'b10100, 1});
    vecs.push_back('{OP_SHL,  16'hC000, 16'h0001, 1'b0, 16'h8002, 5'b11001, 1});
    vecs.push_back('{OP_SHR,  16'h8000, 16'h0003, 1'b0, 16'h4001, 5'b10011, 1});
    vecs.push_back('{OP_SAR,  16'h8002, 16'h0000, 1'b0, 16'hC001, 5'b01000, 1});
    vecs.push_back('{OP_MUL,  16'h0100, 16'h0100, 1'b0, 16'h0000, 5'b10111, 17});
    vecs.push_back('{OP_MUL,  16'h1234, 16'h0003, 1'b0, 16'h369C, 5'b10000, 17});
    vecs.push_back('{OP_MUL,  16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 5'b00011, 17});
    vecs.push_back('{OP_DIV,  16'd100,  16'd7,    1'b0, 16'h000E, 5'b00000, 17});
    vecs.push_back('{OP_MOD,  16'd100,  16'd7,    1'b0, 16'h0002, 5'b00000, 17});
    vecs.push_back('{OP_DIV,  16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 5'b11000, 17});
    vecs.push_back('{OP_DIV,  16'h1234, 16'h0000, 1'b0, 16'hFFFF, 5'b11011, 1});
    vecs.push_back('{OP_MOD,  16'h0005, 16'h0000, 1'b0, 16'hFFFF, 5'b11011, 1});
    vecs.push_back('{OP_ROR,  16'h0001, 16'h0000, 1'b0, 16'h8000, 5'b01001, 1});
    vecs.push_back('{OP_RSV,  16'h1234, 16'h5678, 1'b1, 16'h0000, 5'b10100, 1});

    repeat (2) @(negedge clk);
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_flags", 32'(flags), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].exp_fl));
    end

    // start pulsed while a multiply is busy must be dropped
    start_op(OP_MUL, 16'd3, 16'd5, 1'b0);
    nbusy = 0; ndone = 0;
    for (int i = 0; i < 25; i++) begin
      nbusy += int'(busy);
      ndone += int'(done);
      if (i == 4) begin
        opcode = OP_ADC; in1 = 16'h0001; in2 = 16'h0001; start = 1'b1;
      end
      if (i == 5) start = 1'b0;
      @(negedge clk);
    end
    chk("busy_ignore_out", 32'(out), 32'h000F);
    chk("busy_ignore_done_count", 32'(ndone), 32'd1);
    chk("busy_ignore_busy_cycles", 32'(nbusy), 32'd16);

    // asynchronous reset in the middle of a divide
    start_op(OP_DIV, 16'd100, 16'd7, 1'b0);
    repeat (7) @(negedge clk);
    chk("mid_div_busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", 32'(out), 32'h0);
    chk("async_rst_flags", 32'(flags), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    start_op(OP_ADC, 16'd2, 16'd2, 1'b0);
    wait_done(lat);
    chk("post_rst_adc_latency", 32'(lat), 32'd1);
    chk("post_rst_adc_out", 32'(out), 32'h0004);
    chk("post_rst_adc_flags", 32'(flags), 32'h0);

    // output enable gates only the result bus
    oe = 1'b0;
    start_op(OP_ROL, 16'h8001, 16'h0000, 1'b0);
    wait_done(lat);
    chk("rol_oe0_out", 32'(out), 32'h0);
    chk("rol_oe0_flags", 32'(flags), 32'b10001);
    oe = 1'b1;
    #1;
    chk("rol_oe1_out", 32'(out), 32'h0003);
    repeat (3) @(negedge clk);
    chk("result_hold", 32'(out), 32'h0003);
    chk("done_one_pulse", 32'(done), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
